// File: rtl/fwd_clk_monitor.sv
// fwd_clk_monitor: forwarded LVDS clock receiver and frequency lock monitor.
// Ports: clk_in, rst (sync, active-low); fwdclk_p/n in; locked, err, meas_valid, meas, led out.
// Optional LED_BLINK_EN: led blinks with a 2-window period while locked, dark otherwise.
// Also holds a behavioural CC_LVDS_IBUF model, replaced by the vendor cell at synthesis.

module fwd_clk_monitor #(
  parameter int unsigned LOG2WIN      = 16,
  parameter int unsigned EXP_MIN      = 16300,
  parameter int unsigned EXP_MAX      = 16468,
  parameter int unsigned LOCK_WINDOWS = 4
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               fwdclk_p,
  input  logic               fwdclk_n,
  output logic               locked,
  output logic               err,
  output logic               meas_valid,
  output logic [LOG2WIN-1:0] meas,
  output logic               led
);

  typedef enum logic [1:0] {
    S_ACQ,
    S_LOCK,
    S_FAULT
  } state_e;

  localparam logic [3:0] LOCK_N = 4'(LOCK_WINDOWS);
  localparam logic [LOG2WIN-1:0] ONE =
    {{(LOG2WIN-1){1'b0}}, 1'b1};

  logic               fwd_buf;
  logic               s1_q, s2_q, s3_q;
  logic               edge_det;
  logic               we;
  logic               in_range;
  logic [LOG2WIN-1:0] meas_new;

  logic [LOG2WIN-1:0] win_cnt_q, win_cnt_d;
  logic [LOG2WIN-1:0] edge_cnt_q, edge_cnt_d;
  logic [LOG2WIN-1:0] meas_q, meas_d;
  logic               meas_valid_q, meas_valid_d;
  logic [3:0]         good_cnt_q, good_cnt_d;
  logic               err_q, err_d;
  state_e             state_q, state_d;

  CC_LVDS_IBUF u_ibuf (
    .I_P (fwdclk_p),
    .I_N (fwdclk_n),
    .Y   (fwd_buf)
  );

  // s1/s2 resynchronise the foreign clock, s3 is the edge-detect delay.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= fwd_buf;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    edge_det     = s2_q & ~s3_q;
    we           = &win_cnt_q;
    // an edge landing in the window-end cycle belongs to the closing window
    meas_new     = edge_cnt_q + {{(LOG2WIN-1){1'b0}}, edge_det};
    in_range     = (32'(meas_new) >= EXP_MIN) &&
                   (32'(meas_new) <= EXP_MAX);
    win_cnt_d    = win_cnt_q + ONE;
    edge_cnt_d   = we ? '0 : meas_new;
    meas_d       = we ? meas_new : meas_q;
    meas_valid_d = we;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = err_q;
    if (we) begin
      unique case (state_q)
        S_LOCK: begin
          if (!in_range) begin
            state_d = S_FAULT;
            err_d   = 1'b1;
          end
        end
        default: begin
          // acquire and fault share the good-window count
          if (!in_range) begin
            good_cnt_d = '0;
          end else if (good_cnt_q + 4'd1 == LOCK_N) begin
            state_d    = S_LOCK;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      meas_q       <= '0;
      meas_valid_q <= 1'b0;
      good_cnt_q   <= '0;
      err_q        <= 1'b0;
      state_q      <= S_ACQ;
    end else begin
      win_cnt_q    <= win_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      meas_q       <= meas_d;
      meas_valid_q <= meas_valid_d;
      good_cnt_q   <= good_cnt_d;
      err_q        <= err_d;
      state_q      <= state_d;
    end
  end

  assign locked     = (state_q == S_LOCK);
  assign err        = err_q;
  assign meas       = meas_q;
  assign meas_valid = meas_valid_q;

`ifdef LED_BLINK_EN
  logic toggle_q, toggle_d;

  always_comb begin
    toggle_d = locked ? (toggle_q ^ we) : 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign led = locked & toggle_q;
`else
  assign led = locked;
`endif

endmodule

module CC_LVDS_IBUF (
  input  logic I_P,
  input  logic I_N,
  output logic Y
);
  assign Y = I_P & ~I_N;
endmodule

// File: tb/tb_fwd_clk_monitor.sv
// tb_fwd_clk_monitor: table-driven scenarios plus randomized windows
// against a window-level reference model of fwd_clk_monitor.

module tb_fwd_clk_monitor;

  localparam int LW    = 6;
  localparam int WIN   = 64;
  localparam int EMIN  = 15;
  localparam int EMAX  = 17;
  localparam int LOCKN = 2;
`ifdef LED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef enum int {
    M_LOW, M_HIGH, M_DIV4, M_DIV2, M_BURST, M_RAND
  } mode_e;

  typedef struct {
    mode_e mode;
    int    mlo;
    int    mhi;
    bit    lk;
    bit    er;
    bit    ld;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst = 1'b0;
  logic fwdclk_p = 1'b0;
  logic fwdclk_n = 1'b1;
  logic locked, err, meas_valid, led;
  logic [LW-1:0] meas;

  mode_e mode = M_DIV4;
  int burst_left = 0;
  int ph = 0;
  bit p = 1'b0;

  int checks = 0;
  int errors = 0;
  int mon_prints = 0;

  // reference model state
  bit samp[$];
  int m_edges, good, lockwins;
  bit m_locked, m_err, m_mv, m_led;
  logic [LW-1:0] m_meas;

  vec_t tbl[18];

  fwd_clk_monitor #(
    .LOG2WIN(LW), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
    .LOCK_WINDOWS(LOCKN)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .fwdclk_p   (fwdclk_p),
    .fwdclk_n   (fwdclk_n),
    .locked     (locked),
    .err        (err),
    .meas_valid (meas_valid),
    .meas       (meas),
    .led        (led)
  );

  initial forever #5 clk_in = ~clk_in;

  // forwarded clock generator
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      ph++;
      case (mode)
        M_LOW:  p = 1'b0;
        M_HIGH: p = 1'b1;
        M_DIV4: p = ph[1];
        M_DIV2: p = ~p;
        M_BURST: begin
          if (burst_left > 0) begin
            if (!p) p = 1'b1;
            else begin
              p = 1'b0;
              burst_left--;
            end
          end else p = 1'b0;
        end
        default: if ($urandom_range(0, 1) == 1) p = ~p;
      endcase
      fwdclk_p = p;
      fwdclk_n = ~p;
    end
  end

  task automatic m_reset();
    samp.delete();
    m_edges  = 0;
    good     = 0;
    lockwins = 0;
    m_locked = 0;
    m_err    = 0;
    m_mv     = 0;
    m_led    = 0;
    m_meas   = '0;
  endtask

  // Rising edges at the pins (pre-reset samples read as 0) reach the
  // counter 2..3 samples later; each 64-sample window reports its total.
  task automatic m_step(input bit pin);
    int j;
    bit a, b, inr;
    samp.push_back(pin);
    j = samp.size() - 1;
    a = (j >= 2) ? samp[j-2] : 1'b0;
    b = (j >= 3) ? samp[j-3] : 1'b0;
    m_edges += int'(a & ~b);
    m_mv = 0;
    if (j % WIN == WIN - 1) begin
      m_mv   = 1;
      m_meas = m_edges[LW-1:0];
      inr    = (m_edges >= EMIN) && (m_edges <= EMAX);
      lockwins = m_locked ? lockwins + 1 : 0;
      if (m_locked) begin
        if (!inr) begin
          m_locked = 0;
          m_err    = 1;
        end
      end else begin
        good = inr ? good + 1 : 0;
        if (good >= LOCKN) begin
          m_locked = 1;
          good     = 0;
        end
      end
      m_edges = 0;
    end
    m_led = m_locked && (!BLINK || lockwins[0]);
  endtask

  // cycle-by-cycle comparison against the model
  initial begin
    m_reset();
    forever begin
      @(negedge clk_in);
      checks++;
      if ({locked, err, meas_valid, meas, led} !==
          {m_locked, m_err, m_mv, m_meas, m_led}) begin
        errors++;
        if (mon_prints < 10) begin
          mon_prints++;
          $display("FAIL model t=%0t got lk=%b er=%b mv=%b meas=%0d led=%b expected lk=%b er=%b mv=%b meas=%0d led=%b",
                   $time, locked, err, meas_valid, meas, led,
                   m_locked, m_err, m_mv, m_meas, m_led);
        end
      end
      if (rst !== 1'b1) m_reset();
      else m_step(fwdclk_p);
    end
  end

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_mv(output bit ok);
    ok = 0;
    for (int i = 0; i < 3 * WIN; i++) begin
      @(negedge clk_in);
      if (meas_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int n;
    tbl[0]  = '{M_DIV4,  15, 16, 0, 0, 0};
    tbl[1]  = '{M_DIV4,  16, 16, 1, 0, !BLINK};
    tbl[2]  = '{M_DIV4,  16, 16, 1, 0, 1};
    tbl[3]  = '{M_LOW,    0,  4, 0, 1, 0};
    tbl[4]  = '{M_DIV4,  15, 16, 0, 1, 0};
    tbl[5]  = '{M_DIV4,  16, 16, 1, 1, !BLINK};
    tbl[6]  = '{M_DIV4,  16, 16, 1, 1, 1};
    tbl[7]  = '{M_HIGH,   0,  2, 0, 1, 0};
    tbl[8]  = '{M_HIGH,   0,  0, 0, 1, 0};
    tbl[9]  = '{M_DIV2,  28, 32, 0, 1, 0};
    tbl[10] = '{M_DIV2,  32, 32, 0, 1, 0};
    tbl[11] = '{M_DIV2,  32, 32, 0, 1, 0};
    tbl[12] = '{M_LOW,    0,  4, 0, 1, 0};
    tbl[13] = '{M_BURST, 15, 15, 0, 1, 0};
    tbl[14] = '{M_DIV2,  28, 32, 0, 1, 0};
    tbl[15] = '{M_BURST, 15, 16, 0, 1, 0};
    tbl[16] = '{M_BURST, 15, 15, 1, 1, !BLINK};
    tbl[17] = '{M_LOW,    0,  4, 0, 1, 0};

    // reset held with the forwarded clock toggling
    rst = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    chk("reset_out", {11'd0, locked, err, meas_valid, led, 1'b0}, 16'd0);
    chk("reset_meas", 16'(meas), 16'd0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      mode = tbl[i].mode;
      burst_left = 15;
      wait_mv(ok);
      chk($sformatf("row%0d_mv_seen", i), 16'(ok), 16'd1);
      if (ok) begin
        checks++;
        if (int'(meas) < tbl[i].mlo || int'(meas) > tbl[i].mhi) begin
          errors++;
          $display("FAIL row%0d_meas: got %0d expected %0d..%0d",
                   i, meas, tbl[i].mlo, tbl[i].mhi);
        end
        chk($sformatf("row%0d_status", i),
            {13'd0, locked, err, led},
            {13'd0, tbl[i].lk, tbl[i].er, tbl[i].ld});
      end
    end

    // single-cycle reset while in fault
    repeat (10) @(posedge clk_in);
    #1;
    chk("pre_rst_err", 16'(err), 16'd1);
    rst = 1'b0;
    @(posedge clk_in);
    #1;
    chk("rst_fault_out", {12'd0, locked, err, meas_valid, led}, 16'd0);
    chk("rst_fault_meas", 16'(meas), 16'd0);
    rst = 1'b1;
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk_in);
      #1;
      n = k;
      if (meas_valid === 1'b1) break;
    end
    chk("rst_to_mv", 16'(n), 16'd64);
    chk("rst_first_meas", 16'(meas), 16'd0);

    // randomized windows, checked by the model
    for (int w = 0; w < 24; w++) begin
      mode = mode_e'($urandom_range(0, 5));
      burst_left = $urandom_range(10, 20);
      wait_mv(ok);
      chk($sformatf("rand%0d_mv_seen", w), 16'(ok), 16'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
